// File: rtl/bcd_seg_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : bcd_seg_driver
// Purpose  : Binary-to-BCD (double-dabble) converter + 4-digit 7-seg digit mux
// Revision : 1.0
// ============================================================================
module bcd_seg_driver #(
  parameter int WIDTH    = 14,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] value,
  input  logic             load,
  input  logic [3:0]       sel,
  output logic             busy,
  output logic             ovf,
  output logic [3:0]       an,
  output logic [6:0]       seg
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] C_MAX_VAL = WIDTH'(9999);
  localparam logic [3:0]       C_LAST_IT = 4'd13;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [13:0] shreg_q, shreg_d;
  logic [15:0] scratch_q, scratch_d;
  logic        pend_q, pend_d;
  logic [15:0] digits_q, digits_d;
  logic        ovf_q, ovf_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;

  logic [15:0] scratch_adj;
  logic [3:0]  cur_digit;
  logic        cur_valid;
  logic        cur_blank;
  logic        blank3, blank2, blank1;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'b1000000;
      4'd1:    seg_code = 7'b1111001;
      4'd2:    seg_code = 7'b0100100;
      4'd3:    seg_code = 7'b0110000;
      4'd4:    seg_code = 7'b0011001;
      4'd5:    seg_code = 7'b0010010;
      4'd6:    seg_code = 7'b0000010;
      4'd7:    seg_code = 7'b1111000;
      4'd8:    seg_code = 7'b0000000;
      4'd9:    seg_code = 7'b0010000;
      default: seg_code = 7'b1111111;
    endcase
  endfunction

  // Conversion FSM and datapath
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    scratch_d = scratch_q;
    pend_d    = pend_q;
    digits_d  = digits_q;
    ovf_d     = ovf_q;

    scratch_adj = {add3(scratch_q[15:12]), add3(scratch_q[11:8]),
                   add3(scratch_q[7:4]),   add3(scratch_q[3:0])};

    case (state_q)
      ST_IDLE: begin
        if (load) begin
          pend_d    = (value > C_MAX_VAL);
          shreg_d   = (value > C_MAX_VAL) ? 14'd9999 : value[13:0];
          scratch_d = 16'd0;
          cnt_d     = 4'd0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        scratch_d = {scratch_adj[14:0], shreg_q[13]};
        shreg_d   = {shreg_q[12:0], 1'b0};
        cnt_d     = cnt_q + 4'd1;
        if (cnt_q == C_LAST_IT) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        digits_d = scratch_q;
        ovf_d    = pend_q;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Digit mux with leading-zero blanking; registered so an/seg move together
  always_comb begin
    blank3 = BLANK_LZ && (digits_q[15:12] == 4'd0);
    blank2 = blank3 && (digits_q[11:8] == 4'd0);
    blank1 = blank2 && (digits_q[7:4] == 4'd0);

    cur_digit = 4'd0;
    cur_valid = 1'b1;
    cur_blank = 1'b0;
    case (sel)
      4'b0001: cur_digit = digits_q[3:0];
      4'b0010: begin cur_digit = digits_q[7:4];   cur_blank = blank1; end
      4'b0100: begin cur_digit = digits_q[11:8];  cur_blank = blank2; end
      4'b1000: begin cur_digit = digits_q[15:12]; cur_blank = blank3; end
      default: cur_valid = 1'b0;
    endcase

    an_d  = cur_valid ? ~sel : 4'b1111;
    seg_d = (cur_valid && !cur_blank) ? seg_code(cur_digit) : 7'b1111111;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      shreg_q   <= 14'd0;
      scratch_q <= 16'd0;
      pend_q    <= 1'b0;
      digits_q  <= 16'd0;
      ovf_q     <= 1'b0;
      an_q      <= 4'b1111;
      seg_q     <= 7'b1111111;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      scratch_q <= scratch_d;
      pend_q    <= pend_d;
      digits_q  <= digits_d;
      ovf_q     <= ovf_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign ovf  = ovf_q;
  assign an   = an_q;
  assign seg  = seg_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_seg_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_bcd_seg_driver
// Purpose  : Directed self-checking bench for bcd_seg_driver
// Revision : 1.0
// ============================================================================
module tb_bcd_seg_driver;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S7 = 7'b1111000, S9 = 7'b0010000, SB = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] value;
  logic        load;
  logic [3:0]  sel;
  logic        busy, ovf, busy_nb, ovf_nb;
  logic [3:0]  an, an_nb;
  logic [6:0]  seg, seg_nb;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bcd_seg_driver #(.WIDTH(14), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load), .sel(sel),
    .busy(busy), .ovf(ovf), .an(an), .seg(seg)
  );

  bcd_seg_driver #(.WIDTH(14), .BLANK_LZ(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load), .sel(sel),
    .busy(busy_nb), .ovf(ovf_nb), .an(an_nb), .seg(seg_nb)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load(input logic [13:0] v);
    value = v;
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    logic [3:0] an_exp [4];
    logic [3:0] sel_v  [4];
    rst_n = 1'b0; load = 1'b0; value = '0; sel = 4'b0001;
    #12;
    n_vec++; if (busy !== 1'b0 || ovf !== 1'b0) begin n_err++; $display("FAIL reset_flags busy=%b ovf=%b want 0 0", busy, ovf); end
    n_vec++; if (an !== 4'b1111 || seg !== SB) begin n_err++; $display("FAIL reset_disp an=%b seg=%b want 1111 1111111", an, seg); end
    @(negedge clk); rst_n = 1'b1;
    sel_v[0] = 4'b0001; sel_v[1] = 4'b0010; sel_v[2] = 4'b0100; sel_v[3] = 4'b1000;
    an_exp[0] = 4'b1110; an_exp[1] = 4'b1101; an_exp[2] = 4'b1011; an_exp[3] = 4'b0111;
    for (int i = 0; i < 4; i++) begin
      sel = sel_v[i];
      step();
      n_vec++; if (an !== an_exp[i]) begin n_err++; $display("FAIL reset_an%0d got %b want %b", i, an, an_exp[i]); end
      n_vec++; if (seg !== ((i == 0) ? S0 : SB)) begin n_err++; $display("FAIL reset_seg%0d got %b want %b", i, seg, (i == 0) ? S0 : SB); end
    end
  endtask

  task automatic test_convert_1234();
    int cnt;
    sel = 4'b0001;
    step();
    pulse_load(14'd1234);
    cnt = 0;
    while (busy && cnt < 40) begin
      cnt++;
      if (cnt == 8) begin
        n_vec++; if (seg !== S0) begin n_err++; $display("FAIL hold_old_display got %b want %b", seg, S0); end
      end
      step();
    end
    n_vec++; if (cnt !== 15) begin n_err++; $display("FAIL busy_len got %0d want 15", cnt); end
    sel = 4'b1000; step();
    n_vec++; if (an !== 4'b0111 || seg !== S1) begin n_err++; $display("FAIL d3_1234 an=%b seg=%b want 0111 %b", an, seg, S1); end
    sel = 4'b0100; step();
    n_vec++; if (seg !== S2) begin n_err++; $display("FAIL d2_1234 got %b want %b", seg, S2); end
    sel = 4'b0010; step();
    n_vec++; if (seg !== S3) begin n_err++; $display("FAIL d1_1234 got %b want %b", seg, S3); end
    sel = 4'b0001; step();
    n_vec++; if (seg !== S4 || ovf !== 1'b0) begin n_err++; $display("FAIL d0_1234 seg=%b ovf=%b want %b 0", seg, ovf, S4); end
  endtask

  task automatic test_overflow();
    bit ok;
    logic [3:0] sel_v [4];
    sel_v[0] = 4'b0001; sel_v[1] = 4'b0010; sel_v[2] = 4'b0100; sel_v[3] = 4'b1000;
    pulse_load(14'd10000);
    wait_idle(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL ovf_timeout busy=%b want 0", busy); end
    n_vec++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_set got %b want 1", ovf); end
    for (int i = 0; i < 4; i++) begin
      sel = sel_v[i]; step();
      n_vec++; if (seg !== S9) begin n_err++; $display("FAIL sat_digit%0d got %b want %b", i, seg, S9); end
    end
    pulse_load(14'd5);
    wait_idle(ok);
    n_vec++; if (!ok || ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clear ok=%b ovf=%b want 1 0", ok, ovf); end
    sel = 4'b0001; step();
    n_vec++; if (seg !== S5) begin n_err++; $display("FAIL five_units got %b want %b", seg, S5); end
    sel = 4'b0010; step();
    n_vec++; if (seg !== SB) begin n_err++; $display("FAIL five_tens got %b want %b", seg, SB); end
    sel = 4'b1000; step();
    n_vec++; if (seg !== SB) begin n_err++; $display("FAIL five_thous got %b want %b", seg, SB); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit busy_seen;
    pulse_load(14'd7);
    repeat (4) step();
    pulse_load(14'd4321);
    wait_idle(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL b2b_timeout busy=%b want 0", busy); end
    busy_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (busy) busy_seen = 1'b1;
    end
    n_vec++; if (busy_seen) begin n_err++; $display("FAIL b2b_restart busy_seen=%b want 0", busy_seen); end
    sel = 4'b0001; step();
    n_vec++; if (seg !== S7) begin n_err++; $display("FAIL b2b_units got %b want %b", seg, S7); end
    sel = 4'b0010; step();
    n_vec++; if (seg !== SB) begin n_err++; $display("FAIL b2b_tens got %b want %b", seg, SB); end
    sel = 4'b1000; step();
    n_vec++; if (seg !== SB) begin n_err++; $display("FAIL b2b_thous got %b want %b", seg, SB); end
  endtask

  task automatic test_no_blank_and_sel();
    bit ok;
    logic [3:0] sel_v [4];
    sel_v[0] = 4'b0001; sel_v[1] = 4'b0010; sel_v[2] = 4'b0100; sel_v[3] = 4'b1000;
    pulse_load(14'd0);
    wait_idle(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL zero_timeout busy=%b want 0", busy); end
    for (int i = 0; i < 4; i++) begin
      sel = sel_v[i]; step();
      n_vec++; if (seg_nb !== S0 || an_nb !== ~sel_v[i]) begin n_err++; $display("FAIL nolz_digit%0d an=%b seg=%b want %b %b", i, an_nb, seg_nb, ~sel_v[i], S0); end
      if (i == 2) begin
        n_vec++; if (seg !== SB) begin n_err++; $display("FAIL lz_hund got %b want %b", seg, SB); end
      end
    end
    sel = 4'b0000; step();
    n_vec++; if (an !== 4'b1111 || seg !== SB) begin n_err++; $display("FAIL sel_none an=%b seg=%b want 1111 1111111", an, seg); end
    sel = 4'b0101; step();
    n_vec++; if (an_nb !== 4'b1111 || seg_nb !== SB) begin n_err++; $display("FAIL sel_multi an=%b seg=%b want 1111 1111111", an_nb, seg_nb); end
  endtask

  task automatic test_reset_mid_conv();
    bit busy_seen;
    sel = 4'b0001;
    pulse_load(14'd8888);
    repeat (6) step();
    #1 rst_n = 1'b0;
    #1;
    n_vec++; if (busy !== 1'b0 || ovf !== 1'b0 || an !== 4'b1111 || seg !== SB) begin n_err++; $display("FAIL midrst busy=%b ovf=%b an=%b seg=%b want 0 0 1111 1111111", busy, ovf, an, seg); end
    #1 rst_n = 1'b1;
    step();
    n_vec++; if (an !== 4'b1110 || seg !== S0) begin n_err++; $display("FAIL postrst_units an=%b seg=%b want 1110 %b", an, seg, S0); end
    busy_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (busy) busy_seen = 1'b1;
    end
    n_vec++; if (busy_seen) begin n_err++; $display("FAIL postrst_busy seen=%b want 0", busy_seen); end
    sel = 4'b1000; step();
    n_vec++; if (seg !== SB) begin n_err++; $display("FAIL late_commit got %b want %b", seg, SB); end
  endtask

  initial begin
    test_reset();
    test_convert_1234();
    test_overflow();
    test_back_to_back();
    test_no_blank_and_sel();
    test_reset_mid_conv();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
